// File: rtl/way_age_victim_ctrl_pkg.sv
// Shared replacement-controller definitions: FSM encoding, default geometry
// and the age saturation helper used by the victim controller.
package way_age_victim_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEL  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int DEF_NUM_WAY   = 16;
   localparam int DEF_NUM_SET   = 4;
   localparam int DEF_AGE_WIDTH = 4;

   localparam int DEF_WAY_IDX_W = $clog2(DEF_NUM_WAY);
   localparam int DEF_SET_IDX_W = $clog2(DEF_NUM_SET);

   // Largest value an age counter of the given width can hold.
   function automatic int age_sat_val(input int width);
      return (1 << width) - 1;
   endfunction

endpackage

// File: rtl/way_age_victim_ctrl_max_age_select.sv
// Masked maximum-age search over a flattened age vector; on equal ages the
// lowest way index wins.
module max_age_select #(
   parameter int NUM_WAY   = 16,
   parameter int AGE_WIDTH = 4,
   parameter int WAY_IDX_W = $clog2(NUM_WAY)
) (
   input  logic [NUM_WAY*AGE_WIDTH-1:0] ages_in,
   input  logic [NUM_WAY-1:0]           mask_in,
   output logic                         found_out,
   output logic [WAY_IDX_W-1:0]         way_out,
   output logic [AGE_WIDTH-1:0]         age_out
);

   always_comb begin
      found_out = 1'b0;
      way_out   = '0;
      age_out   = '0;
      // Strict greater-than keeps the earliest way on ties.
      for (int i = 0; i < NUM_WAY; i++) begin
         if (mask_in[i] && (!found_out || (ages_in[i*AGE_WIDTH +: AGE_WIDTH] > age_out))) begin
            found_out = 1'b1;
            way_out   = WAY_IDX_W'(i);
            age_out   = ages_in[i*AGE_WIDTH +: AGE_WIDTH];
         end
      end
   end

endmodule

// File: rtl/way_age_victim_ctrl.sv
// Per-set, per-way saturating age tracking with a three-state victim
// selection engine behind a valid/ready request/response handshake.
module way_age_victim_ctrl
   import way_age_victim_ctrl_pkg::*;
#(
   parameter int NUM_WAY   = DEF_NUM_WAY,
   parameter int NUM_SET   = DEF_NUM_SET,
   parameter int AGE_WIDTH = DEF_AGE_WIDTH,
   parameter int WAY_IDX_W = $clog2(NUM_WAY),
   parameter int SET_IDX_W = $clog2(NUM_SET)
) (
   input  logic                 clk_in,
   input  logic                 reset_n_in,
   input  logic                 upd_valid_in,
   input  logic [SET_IDX_W-1:0] upd_set_in,
   input  logic [WAY_IDX_W-1:0] upd_way_in,
   input  logic                 req_valid_in,
   output logic                 req_ready_out,
   input  logic [SET_IDX_W-1:0] req_set_in,
   input  logic [NUM_WAY-1:0]   req_line_valid_in,
   input  logic [NUM_WAY-1:0]   req_lock_in,
   output logic                 resp_valid_out,
   input  logic                 resp_ready_in,
   output logic [WAY_IDX_W-1:0] resp_way_out,
   output logic                 resp_none_out,
   output logic [AGE_WIDTH-1:0] resp_age_out
);

   localparam logic [AGE_WIDTH-1:0] AGE_SAT = AGE_WIDTH'(age_sat_val(AGE_WIDTH));

   function automatic logic [AGE_WIDTH-1:0] sat_inc(input logic [AGE_WIDTH-1:0] a);
      return (a == AGE_SAT) ? a : a + 1'b1;
   endfunction

   state_e state_q, state_d;
   logic [AGE_WIDTH-1:0] age_q [NUM_SET][NUM_WAY];
   logic [AGE_WIDTH-1:0] age_d [NUM_SET][NUM_WAY];

   logic [NUM_WAY*AGE_WIDTH-1:0] snap_ages_q, snap_ages_d;
   logic [NUM_WAY-1:0]           snap_valid_q, snap_valid_d;
   logic [NUM_WAY-1:0]           snap_lock_q, snap_lock_d;

   logic [WAY_IDX_W-1:0] resp_way_q, resp_way_d;
   logic                 resp_none_q, resp_none_d;
   logic [AGE_WIDTH-1:0] resp_age_q, resp_age_d;

   logic                 accept;
   logic [NUM_WAY-1:0]   eligible;
   logic [NUM_WAY-1:0]   elig_invalid;
   logic                 inv_found;
   logic [WAY_IDX_W-1:0] inv_way;
   logic                 max_found;
   logic [WAY_IDX_W-1:0] max_way;
   logic [AGE_WIDTH-1:0] max_age;

   assign accept = (state_q == ST_IDLE) && req_valid_in;

   always_comb begin
      age_d = age_q;
      if (upd_valid_in) begin
         for (int w = 0; w < NUM_WAY; w++) begin
            if (w == int'(upd_way_in)) age_d[upd_set_in][w] = '0;
            else                       age_d[upd_set_in][w] = sat_inc(age_q[upd_set_in][w]);
         end
      end
   end

   // Snapshot reads storage before this edge's update lands.
   always_comb begin
      snap_ages_d  = snap_ages_q;
      snap_valid_d = snap_valid_q;
      snap_lock_d  = snap_lock_q;
      if (accept) begin
         for (int w = 0; w < NUM_WAY; w++) snap_ages_d[w*AGE_WIDTH +: AGE_WIDTH] = age_q[req_set_in][w];
         snap_valid_d = req_line_valid_in;
         snap_lock_d  = req_lock_in;
      end
   end

   always_ff @(posedge clk_in) begin
      snap_ages_q  <= snap_ages_d;
      snap_valid_q <= snap_valid_d;
      snap_lock_q  <= snap_lock_d;
   end

   assign eligible     = ~snap_lock_q;
   assign elig_invalid = eligible & ~snap_valid_q;

   always_comb begin
      inv_found = 1'b0;
      inv_way   = '0;
      for (int i = 0; i < NUM_WAY; i++) begin
         if (elig_invalid[i] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAY_IDX_W'(i);
         end
      end
   end

   max_age_select #(
      .NUM_WAY   (NUM_WAY),
      .AGE_WIDTH (AGE_WIDTH),
      .WAY_IDX_W (WAY_IDX_W)
   ) u_max_sel (
      .ages_in   (snap_ages_q),
      .mask_in   (eligible),
      .found_out (max_found),
      .way_out   (max_way),
      .age_out   (max_age)
   );

   always_comb begin
      resp_way_d  = resp_way_q;
      resp_none_d = resp_none_q;
      resp_age_d  = resp_age_q;
      if (state_q == ST_SEL) begin
         if (inv_found) begin
            resp_way_d  = inv_way;
            resp_none_d = 1'b0;
            resp_age_d  = '0;
         end else if (max_found) begin
            resp_way_d  = max_way;
            resp_none_d = 1'b0;
            resp_age_d  = max_age;
         end else begin
            resp_way_d  = '0;
            resp_none_d = 1'b1;
            resp_age_d  = '0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q     <= ST_IDLE;
         resp_way_q  <= '0;
         resp_none_q <= 1'b0;
         resp_age_q  <= '0;
         for (int s = 0; s < NUM_SET; s++)
            for (int w = 0; w < NUM_WAY; w++) age_q[s][w] <= '0;
      end else begin
         state_q     <= state_d;
         resp_way_q  <= resp_way_d;
         resp_none_q <= resp_none_d;
         resp_age_q  <= resp_age_d;
         age_q       <= age_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req_valid_in)  state_d = ST_SEL;
         ST_SEL:                     state_d = ST_RESP;
         ST_RESP: if (resp_ready_in) state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready_out  = (state_q == ST_IDLE);
      resp_valid_out = (state_q == ST_RESP);
      resp_way_out   = resp_way_q;
      resp_none_out  = resp_none_q;
      resp_age_out   = resp_age_q;
   end

endmodule

// File: tb/tb_way_age_victim_ctrl.sv
// Directed bench for way_age_victim_ctrl with hand-computed victim results.
module tb_way_age_victim_ctrl;

   logic        clk;
   logic        reset_n;
   logic        upd_valid;
   logic [1:0]  upd_set;
   logic [3:0]  upd_way;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_set;
   logic [15:0] req_line_valid;
   logic [15:0] req_lock;
   logic        resp_valid;
   logic        resp_ready;
   logic [3:0]  resp_way;
   logic        resp_none;
   logic [3:0]  resp_age;

   int tests = 0;
   int fails = 0;

   way_age_victim_ctrl dut (
      .clk_in            (clk),
      .reset_n_in        (reset_n),
      .upd_valid_in      (upd_valid),
      .upd_set_in        (upd_set),
      .upd_way_in        (upd_way),
      .req_valid_in      (req_valid),
      .req_ready_out     (req_ready),
      .req_set_in        (req_set),
      .req_line_valid_in (req_line_valid),
      .req_lock_in       (req_lock),
      .resp_valid_out    (resp_valid),
      .resp_ready_in     (resp_ready),
      .resp_way_out      (resp_way),
      .resp_none_out     (resp_none),
      .resp_age_out      (resp_age)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_upd(input logic [1:0] s, input logic [3:0] w);
      @(negedge clk);
      upd_valid = 1'b1; upd_set = s; upd_way = w;
      @(negedge clk);
      upd_valid = 1'b0;
   endtask

   // Issue one request, wait (bounded) for the response, then consume it.
   task automatic do_req(input logic [1:0] s, input logic [15:0] v, input logic [15:0] l,
                         output logic [3:0] w, output logic n, output logic [3:0] a,
                         output int lat);
      @(negedge clk);
      req_valid = 1'b1; req_set = s; req_line_valid = v; req_lock = l;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      w = resp_way; n = resp_none; a = resp_age;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid_in_reset got %0b want 0", resp_valid); end
      reset_n = 1'b1;
      @(negedge clk);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got %0b want 1", req_ready); end
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %0b want 0", resp_valid); end
      tests++; if (resp_way !== 4'd0) begin fails++; $display("FAIL rst_resp_way got %0d want 0", resp_way); end
      tests++; if (resp_none !== 1'b0) begin fails++; $display("FAIL rst_resp_none got %0b want 0", resp_none); end
      tests++; if (resp_age !== 4'd0) begin fails++; $display("FAIL rst_resp_age got %0d want 0", resp_age); end
   endtask

   task automatic test_invalid_first();
      logic [3:0] w, a; logic n; int lat;
      do_req(2'd0, 16'h0000, 16'h0000, w, n, a, lat);
      tests++; if (lat !== 2) begin fails++; $display("FAIL inv_latency got %0d want 2", lat); end
      tests++; if ({w, n, a} !== {4'd0, 1'b0, 4'd0}) begin fails++; $display("FAIL inv_all_invalid got way=%0d none=%0b age=%0d want 0/0/0", w, n, a); end
   endtask

   task automatic test_saturate();
      logic [3:0] w, a; logic n; int lat;
      for (int k = 0; k < 16; k++) do_upd(2'd1, 4'(k));
      do_req(2'd1, 16'hFFFF, 16'h0000, w, n, a, lat);
      tests++; if (lat !== 2) begin fails++; $display("FAIL sat_latency got %0d want 2", lat); end
      tests++; if ({w, n, a} !== {4'd0, 1'b0, 4'd15}) begin fails++; $display("FAIL sat_max got way=%0d none=%0b age=%0d want 0/0/15", w, n, a); end
      do_req(2'd1, 16'hFFFF, 16'h0001, w, n, a, lat);
      tests++; if ({w, n, a} !== {4'd1, 1'b0, 4'd14}) begin fails++; $display("FAIL sat_lock0 got way=%0d none=%0b age=%0d want 1/0/14", w, n, a); end
      do_req(2'd1, 16'hFFFF, 16'hFFFF, w, n, a, lat);
      tests++; if ({w, n, a} !== {4'd0, 1'b1, 4'd0}) begin fails++; $display("FAIL sat_all_locked got way=%0d none=%0b age=%0d want 0/1/0", w, n, a); end
   endtask

   task automatic test_tie_and_mask();
      logic [3:0] w, a; logic n; int lat;
      do_upd(2'd3, 4'd0);
      do_upd(2'd3, 4'd1);
      do_req(2'd3, 16'hFFFF, 16'h0000, w, n, a, lat);
      tests++; if ({w, n, a} !== {4'd2, 1'b0, 4'd2}) begin fails++; $display("FAIL tie_set3 got way=%0d none=%0b age=%0d want 2/0/2", w, n, a); end
      do_req(2'd2, 16'hFFFF, 16'h0000, w, n, a, lat);
      tests++; if ({w, n, a} !== {4'd0, 1'b0, 4'd0}) begin fails++; $display("FAIL tie_set2 got way=%0d none=%0b age=%0d want 0/0/0", w, n, a); end
      do_req(2'd2, 16'hFFF7, 16'h0000, w, n, a, lat);
      tests++; if ({w, n, a} !== {4'd3, 1'b0, 4'd0}) begin fails++; $display("FAIL inv_way3 got way=%0d none=%0b age=%0d want 3/0/0", w, n, a); end
      do_req(2'd3, 16'hFFFF, 16'h0004, w, n, a, lat);
      tests++; if ({w, n, a} !== {4'd3, 1'b0, 4'd2}) begin fails++; $display("FAIL tie_lock2 got way=%0d none=%0b age=%0d want 3/0/2", w, n, a); end
      do_req(2'd3, 16'hFF0F, 16'h0030, w, n, a, lat);
      tests++; if ({w, n, a} !== {4'd6, 1'b0, 4'd0}) begin fails++; $display("FAIL inv_locked_skip got way=%0d none=%0b age=%0d want 6/0/0", w, n, a); end
   endtask

   task automatic test_snapshot();
      logic [3:0] w, a; logic n; int lat;
      @(negedge clk);
      req_valid = 1'b1; req_set = 2'd1; req_line_valid = 16'hFFFF; req_lock = 16'h0000;
      upd_valid = 1'b1; upd_set = 2'd1; upd_way = 4'd0;
      @(negedge clk);
      req_valid = 1'b0;
      upd_way = 4'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         upd_valid = 1'b0;
         tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL snap_valid[%0d] got %0b want 1", i, resp_valid); end
         tests++; if ({resp_way, resp_none, resp_age} !== {4'd0, 1'b0, 4'd15}) begin
            fails++; $display("FAIL snap_hold[%0d] got way=%0d none=%0b age=%0d want 0/0/15", i, resp_way, resp_none, resp_age);
         end
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      do_req(2'd1, 16'hFFFF, 16'h0000, w, n, a, lat);
      tests++; if ({w, n, a} !== {4'd2, 1'b0, 4'd15}) begin fails++; $display("FAIL snap_after got way=%0d none=%0b age=%0d want 2/0/15", w, n, a); end
   endtask

   task automatic test_back_to_back();
      logic [5:0] rv_pat, rr_pat;
      rv_pat = '0; rr_pat = '0;
      @(negedge clk);
      req_valid = 1'b1; req_set = 2'd0; req_line_valid = 16'h0000; req_lock = 16'h0000;
      resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rv_pat = {rv_pat[4:0], resp_valid};
         rr_pat = {rr_pat[4:0], req_ready};
      end
      req_valid = 1'b0;
      @(negedge clk);
      resp_ready = 1'b0;
      tests++; if (rv_pat !== 6'b010010) begin fails++; $display("FAIL b2b_resp_valid got %b want 010010", rv_pat); end
      tests++; if (rr_pat !== 6'b001001) begin fails++; $display("FAIL b2b_req_ready got %b want 001001", rr_pat); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] w, a; logic n; int lat;
      @(negedge clk);
      req_valid = 1'b1; req_set = 2'd3; req_line_valid = 16'hFFFF; req_lock = 16'h0000;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      tests++; if ({resp_valid, resp_way, resp_age} !== {1'b1, 4'd2, 4'd2}) begin
         fails++; $display("FAIL mid_pre got valid=%0b way=%0d age=%0d want 1/2/2", resp_valid, resp_way, resp_age);
      end
      #2 reset_n = 1'b0;
      #1;
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL mid_async_drop got %0b want 0", resp_valid); end
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_req_ready got %0b want 1", req_ready); end
      tests++; if (resp_way !== 4'd0) begin fails++; $display("FAIL mid_resp_way got %0d want 0", resp_way); end
      @(negedge clk);
      reset_n = 1'b1;
      do_req(2'd3, 16'hFFFF, 16'h0000, w, n, a, lat);
      tests++; if ({w, n, a} !== {4'd0, 1'b0, 4'd0}) begin fails++; $display("FAIL mid_ages_cleared got way=%0d none=%0b age=%0d want 0/0/0", w, n, a); end
      do_req(2'd1, 16'hFFFF, 16'h0000, w, n, a, lat);
      tests++; if ({w, n, a} !== {4'd0, 1'b0, 4'd0}) begin fails++; $display("FAIL mid_set1_cleared got way=%0d none=%0b age=%0d want 0/0/0", w, n, a); end
   endtask

   initial begin
      reset_n = 1'b0; upd_valid = 1'b0; upd_set = '0; upd_way = '0;
      req_valid = 1'b0; req_set = '0; req_line_valid = '0; req_lock = '0;
      resp_ready = 1'b0;
      test_reset();
      test_invalid_first();
      test_saturate();
      test_tie_and_mask();
      test_snapshot();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
